parity_rr_scheduler: RTL and testbench

//   Shares one even-parity generator among NREQ requesters. Round-robin arbitration

---
 rtl/parity_rr_scheduler.sv | 103 ++++++++++
 tb/tb_parity_rr_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_rr_scheduler.sv
// Round-robin shared even-parity generator: one requester is served per result,
// tagged with its id. Optional PRS_STATS_EN adds a saturating completed-result counter.
module parity_rr_scheduler #(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IW-1:0]     res_id,
  output logic [DW-1:0]     res_data,
  output logic              res_parity
`ifdef PRS_STATS_EN
  , output logic [15:0]     res_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [IW-1:0] cand;
  logic          any_valid;
  logic [DW-1:0] grant_data;
  logic          accept;

  // Scan farthest-first so the nearest valid requester after rr_ptr wins.
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == grant) grant_data = req_data[i*DW +: DW];
    end
  end

  assign accept = (state == IDLE) && any_valid;

  // Gated by rst so a requester is never offered a slot while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (accept && !rst) req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = BUSY;
      BUSY:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= IW'(NREQ - 1);
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_data   <= '0;
      res_parity <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        res_data   <= grant_data;
        res_parity <= ^grant_data;
        res_id     <= grant;
        rr_ptr     <= grant;
        res_valid  <= 1'b1;
      end else if ((state == BUSY) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef PRS_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (res_valid && res_ready && (res_cnt != 16'hFFFF)) begin
      res_cnt <= res_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_rr_scheduler.sv
// Testbench for parity_rr_scheduler: transaction-level reference model plus
// directed scenarios with hand-computed ids and parities.
module tb_parity_rr_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic        res_ready = 1'b0;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [7:0]  res_data;
  logic        res_parity;
`ifdef PRS_STATS_EN
  logic [15:0] res_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  parity_rr_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_data   (res_data),
    .res_parity (res_parity)
`ifdef PRS_STATS_EN
    , .res_cnt  (res_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Reference model: who is served next, and what the held result must be.
  bit         m_valid = 1'b0;
  int         m_ptr   = 3;
  int         m_id    = 0;
  logic [7:0] m_data  = '0;
  bit         m_par   = 1'b0;
  int         m_cnt   = 0;
  int         m_g;

  function automatic int pick(input logic [3:0] v, input int ptr);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int b = 0; b < 8; b++) if (d[b]) n++;
    return n;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (rst || m_valid) return 4'b0000;
    g = pick(req_valid, m_ptr);
    if (g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_ptr = 3; m_id = 0; m_data = '0; m_par = 1'b0; m_cnt = 0;
    end else if (!m_valid) begin
      m_g = pick(req_valid, m_ptr);
      if (m_g >= 0) begin
        m_id    = m_g;
        m_ptr   = m_g;
        m_data  = 8'(req_data >> (8 * m_g));
        m_par   = (ones(m_data) % 2) == 1;
        m_valid = 1'b1;
      end
    end else if (res_ready) begin
      m_valid = 1'b0;
      if (m_cnt < 65535) m_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready()));
    checkOutput("res_valid", 32'(res_valid), 32'(m_valid));
    checkOutput("res_id", 32'(res_id), 32'(m_id));
    checkOutput("res_data", 32'(res_data), 32'(m_data));
    checkOutput("res_parity", 32'(res_parity), 32'(m_par));
`ifdef PRS_STATS_EN
    checkOutput("res_cnt", 32'(res_cnt), 32'(m_cnt));
`endif
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic rdy);
    req_valid = v;
    req_data  = d;
    res_ready = rdy;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic waitResult(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("result_timeout", 32'd0, 32'd1);
  endtask

  localparam logic [31:0] DATA3 = {8'b10100000, 8'b10101000, 8'b00111110, 8'b00101000};

  initial begin
    int ids3 [5]  = '{0, 1, 2, 3, 0};
    int par3 [5]  = '{0, 1, 1, 0, 0};
    logic [7:0] d2 [4] = '{8'h00, 8'b00011000, 8'b11100000, 8'b01111100};
    int par2 [4]  = '{0, 0, 1, 1};
    int ids5 [3]  = '{1, 3, 1};
    int last;

    #1 rst = 1'b1;
    applyStimulus(4'b0000, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_res_parity", 32'(res_parity), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);

    // Reset while a result is held
    #1 rst = 1'b0;
    applyStimulus(4'b1111, DATA3, 1'b0);
    waitResult(10);
    checkOutput("pre_rst_id", 32'(res_id), 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midbusy_res_valid", 32'(res_valid), 32'd0);
    checkOutput("midbusy_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // All four valid, downstream always ready: strict rotation, one result per 2 clk
    waitResult(10);
    last = cycle;
    checkOutput("rr_id0", 32'(res_id), 32'(ids3[0]));
    checkOutput("rr_par0", 32'(res_parity), 32'(par3[0]));
    checkOutput("rr_data0", 32'(res_data), 32'h28);
    #1 res_ready = 1'b1;
    for (int n = 1; n < 5; n++) begin
      waitResult(10);
      checkOutput("rr_id", 32'(res_id), 32'(ids3[n]));
      checkOutput("rr_par", 32'(res_parity), 32'(par3[n]));
      checkOutput("rr_gap", 32'(cycle - last), 32'd2);
      last = cycle;
    end

    // Single requester 0 with several data words
    applyStimulus(4'b0001, {24'd0, d2[0]}, 1'b1);
    resetPulse();
    for (int n = 0; n < 4; n++) begin
      waitResult(10);
      checkOutput("single_id", 32'(res_id), 32'd0);
      checkOutput("single_par", 32'(res_parity), 32'(par2[n]));
      checkOutput("single_data", 32'(res_data), 32'(d2[n]));
      if (n < 3) #1 req_data = {24'd0, d2[n+1]};
    end

    // Backpressure, and requester 1 withdrawing before its turn
    applyStimulus(4'b1111, DATA3, 1'b0);
    resetPulse();
    waitResult(10);
    #1 req_valid = 4'b1101;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_id", 32'(res_id), 32'd0);
      checkOutput("bp_data", 32'(res_data), 32'h28);
      checkOutput("bp_ready", 32'(req_ready), 32'd0);
    end
    #1 res_ready = 1'b1;
    @(negedge clk);
    waitResult(10);
    checkOutput("bp_next_id", 32'(res_id), 32'd2);
    checkOutput("bp_next_par", 32'(res_parity), 32'd1);

    // No requests: stay idle
    #1 req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    checkOutput("idle_valid", 32'(res_valid), 32'd0);
    checkOutput("idle_data", 32'(res_data), 32'hA8);

    // Sparse: only requesters 1 and 3
    applyStimulus(4'b1010, DATA3, 1'b1);
    resetPulse();
    for (int n = 0; n < 3; n++) begin
      waitResult(10);
      checkOutput("sparse_id", 32'(res_id), 32'(ids5[n]));
    end
`ifdef PRS_STATS_EN
    @(negedge clk);
    checkOutput("cnt_three", 32'(res_cnt), 32'd3);
    #1 rst = 1'b1;
    #1;
    checkOutput("cnt_reset", 32'(res_cnt), 32'd0);
    #1 rst = 1'b0;
`endif
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
